// File: rtl/sha256_pkg.sv
// ============================================================================
// sha256_pkg : shared SHA-256 types, round-constant table and bit helpers
// Revision   : 1.0
// ============================================================================
`default_nettype none

package sha256_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } sched_state_e;

   // Element [t] is K_t; the concatenation therefore lists K_63 first.
   localparam logic [63:0][31:0] K_TABLE = {
      32'hc67178f2, 32'hbef9a3f7, 32'ha4506ceb, 32'h90befffa,
      32'h8cc70208, 32'h84c87814, 32'h78a5636f, 32'h748f82ee,
      32'h682e6ff3, 32'h5b9cca4f, 32'h4ed8aa4a, 32'h391c0cb3,
      32'h34b0bcb5, 32'h2748774c, 32'h1e376c08, 32'h19a4c116,
      32'h106aa070, 32'hf40e3585, 32'hd6990624, 32'hd192e819,
      32'hc76c51a3, 32'hc24b8b70, 32'ha81a664b, 32'ha2bfe8a1,
      32'h92722c85, 32'h81c2c92e, 32'h766a0abb, 32'h650a7354,
      32'h53380d13, 32'h4d2c6dfc, 32'h2e1b2138, 32'h27b70a85,
      32'h14292967, 32'h06ca6351, 32'hd5a79147, 32'hc6e00bf3,
      32'hbf597fc7, 32'hb00327c8, 32'ha831c66d, 32'h983e5152,
      32'h76f988da, 32'h5cb0a9dc, 32'h4a7484aa, 32'h2de92c6f,
      32'h240ca1cc, 32'h0fc19dc6, 32'hefbe4786, 32'he49b69c1,
      32'hc19bf174, 32'h9bdc06a7, 32'h80deb1fe, 32'h72be5d74,
      32'h550c7dc3, 32'h243185be, 32'h12835b01, 32'hd807aa98,
      32'hab1c5ed5, 32'h923f82a4, 32'h59f111f1, 32'h3956c25b,
      32'he9b5dba5, 32'hb5c0fbcf, 32'h71374491, 32'h428a2f98
   };

   function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [31:0] shr(input logic [31:0] x, input int unsigned n);
      return x >> n;
   endfunction

endpackage

`default_nettype wire

// File: rtl/sha256_sigma.sv
// ============================================================================
// sha256_sigma : combinational SHA-256 message-schedule sigma0/sigma1 pair
// Revision     : 1.0
// ============================================================================
`default_nettype none

module sha256_sigma
   import sha256_pkg::*;
(
   input  logic [31:0] s0_in,
   input  logic [31:0] s1_in,
   output logic [31:0] s0_out,
   output logic [31:0] s1_out
);

   assign s0_out = rotr(s0_in, 7)  ^ rotr(s0_in, 18) ^ shr(s0_in, 3);
   assign s1_out = rotr(s1_in, 17) ^ rotr(s1_in, 19) ^ shr(s1_in, 10);

endmodule

`default_nettype wire

// File: rtl/sha256_msg_schedule.sv
// ============================================================================
// sha256_msg_schedule : 16-word sliding-window SHA-256 schedule, W_0..W_63
// Optional macro SHA256_KROM_EN streams K_t alongside each word.
// Revision            : 1.0
// ============================================================================
`default_nettype none

module sha256_msg_schedule
   import sha256_pkg::*;
#(
   parameter int N      = 32,
   parameter int ROUNDS = 64
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            blk_valid,
   output logic            blk_ready,
   input  logic [16*N-1:0] blk_data,
   output logic            w_valid,
   input  logic            w_ready,
   output logic [N-1:0]    w_t,
   output logic [N-1:0]    k_t,
   output logic [5:0]      round,
   output logic            last
);

   generate
      if (N != 32) begin : g_width_check
         $error("sha256_msg_schedule: only N=32 is supported");
      end
   endgenerate

   sched_state_e        state_q, state_d;
   logic [15:0][N-1:0]  win_q, win_d;
   logic [5:0]          round_q, round_d;
   logic [N-1:0]        s0_val, s1_val, w_new;
   logic                blk_hs, w_hs;

   assign blk_ready = (state_q == IDLE);
   assign w_valid   = (state_q == RUN);
   assign w_t       = win_q[0];
   assign round     = round_q;
   assign last      = w_valid && (round_q == 6'(ROUNDS - 1));
   assign blk_hs    = blk_valid & blk_ready;
   assign w_hs      = w_valid & w_ready;

`ifdef SHA256_KROM_EN
   assign k_t = w_valid ? K_TABLE[round_q] : '0;
`else
   assign k_t = '0;
`endif

   sha256_sigma u_sigma (
      .s0_in  (win_q[1]),
      .s1_in  (win_q[14]),
      .s0_out (s0_val),
      .s1_out (s1_val)
   );

   // With win[0]=W_t this yields W_{t+16}, which enters at the top of the window.
   assign w_new = s1_val + win_q[9] + s0_val + win_q[0];

   always_comb begin
      state_d = state_q;
      win_d   = win_q;
      round_d = round_q;
      case (state_q)
         IDLE: begin
            if (blk_hs) begin
               for (int i = 0; i < 16; i++) begin
                  win_d[i] = blk_data[16*N-1-N*i -: N];
               end
               round_d = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            if (w_hs) begin
               if (last) begin
                  round_d = '0;
                  state_d = IDLE;
               end else begin
                  for (int i = 0; i < 15; i++) begin
                     win_d[i] = win_q[i+1];
                  end
                  win_d[15] = w_new;
                  round_d   = round_q + 6'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         win_q   <= '0;
         round_q <= '0;
      end else begin
         state_q <= state_d;
         win_q   <= win_d;
         round_q <= round_d;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_sha256_msg_schedule.sv
// ============================================================================
// tb_sha256_msg_schedule : directed self-checking bench for sha256_msg_schedule
// Revision               : 1.0
// ============================================================================
`default_nettype none

module tb_sha256_msg_schedule;

   logic         clock = 1'b0;
   logic         reset = 1'b1;
   logic         blk_valid = 1'b0;
   logic         blk_ready;
   logic [511:0] blk_data = '0;
   logic         w_valid;
   logic         w_ready = 1'b1;
   logic [31:0]  w_t;
   logic [31:0]  k_t;
   logic [5:0]   round;
   logic         last;

   int           n_cmp = 0;
   int           n_bad = 0;
   logic [31:0]  exp_w [64];
   logic [31:0]  got   [64];
   logic [511:0] abc_blk;
   logic [511:0] blk_a;
   logic [511:0] blk_b;

   always #5 clock = ~clock;

   sha256_msg_schedule #(.N(32), .ROUNDS(64)) dut (
      .clock     (clock),
      .reset     (reset),
      .blk_valid (blk_valid),
      .blk_ready (blk_ready),
      .blk_data  (blk_data),
      .w_valid   (w_valid),
      .w_ready   (w_ready),
      .w_t       (w_t),
      .k_t       (k_t),
      .round     (round),
      .last      (last)
   );

   function automatic logic [31:0] ref_s0(input logic [31:0] x);
      return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
   endfunction

   function automatic logic [31:0] ref_s1(input logic [31:0] x);
      return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
   endfunction

   task automatic build_ref(input logic [511:0] b);
      for (int t = 0; t < 16; t++) exp_w[t] = b[511-32*t -: 32];
      for (int t = 16; t < 64; t++)
         exp_w[t] = ref_s1(exp_w[t-2]) + exp_w[t-7] + ref_s0(exp_w[t-15]) + exp_w[t-16];
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic random_block(output logic [511:0] b);
      for (int i = 0; i < 16; i++) b[511-32*i -: 32] = $urandom;
   endtask

   // Present a block for one accepting edge, then scramble blk_data.
   task automatic send_block(input logic [511:0] b);
      @(negedge clock);
      check("blk_ready_idle", 32'(blk_ready), 32'd1);
      blk_valid = 1'b1;
      blk_data  = b;
      @(posedge clock);
      #1;
      blk_valid = 1'b0;
      blk_data  = ~b;
   endtask

   // Consume words 0..stop_at-1, checking every cycle (stall cycles included).
   task automatic run_stream(input int stop_at, input bit rand_ready);
      int t      = 0;
      int budget = 0;
      while (t < stop_at) begin
         @(negedge clock);
         check("w_valid", 32'(w_valid), 32'd1);
         check("blk_ready_run", 32'(blk_ready), 32'd0);
         check("w_t", w_t, exp_w[t]);
         check("round", 32'(round), 32'(t));
         check("last", 32'(last), 32'(t == 63));
`ifdef SHA256_KROM_EN
         if (t == 0)  check("k_t_r0", k_t, 32'h428A2F98);
         if (t == 63) check("k_t_r63", k_t, 32'hC67178F2);
`else
         check("k_t_zero", k_t, 32'd0);
`endif
         got[t]  = w_t;
         w_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         @(posedge clock);
         if (w_ready) t++;
         budget++;
         if (budget > 2000) begin
            n_cmp++;
            n_bad++;
            $error("FAIL stream_timeout: observed %0d words expected %0d", t, stop_at);
            break;
         end
      end
   endtask

   initial begin
      abc_blk = {32'h61626380, 448'd0, 32'h00000018};

      // Reset state
      #1;
      check("rst_blk_ready", 32'(blk_ready), 32'd1);
      check("rst_w_valid", 32'(w_valid), 32'd0);
      check("rst_w_t", w_t, 32'd0);
      check("rst_k_t", k_t, 32'd0);
      check("rst_round", 32'(round), 32'd0);
      check("rst_last", 32'(last), 32'd0);
      @(negedge clock);
      reset = 1'b0;

      // "abc" block at full throughput
      build_ref(abc_blk);
      send_block(abc_blk);
      run_stream(64, 1'b0);
      check("abc_w0", got[0], 32'h61626380);
      check("abc_w15", got[15], 32'h00000018);
      check("abc_w16", got[16], 32'h61626380);
      check("abc_w17", got[17], 32'h000F0000);
      check("abc_w18", got[18], 32'h7DA86405);
      check("abc_w19", got[19], 32'h600003C6);

      // "abc" block with random back-pressure
      send_block(abc_blk);
      run_stream(64, 1'b1);
      check("abc_stall_w19", got[19], 32'h600003C6);
      w_ready = 1'b1;

      // Asynchronous reset mid-burst at round 30
      send_block(abc_blk);
      run_stream(30, 1'b0);
      @(negedge clock);
      check("pre_rst_round", 32'(round), 32'd30);
      reset = 1'b1;
      #1;
      check("mid_rst_w_valid", 32'(w_valid), 32'd0);
      check("mid_rst_blk_ready", 32'(blk_ready), 32'd1);
      check("mid_rst_round", 32'(round), 32'd0);
      check("mid_rst_last", 32'(last), 32'd0);
      check("mid_rst_k_t", k_t, 32'd0);
      @(negedge clock);
      reset = 1'b0;
      send_block(abc_blk);
      run_stream(64, 1'b0);

      // Back-to-back blocks with blk_valid held high throughout
      random_block(blk_a);
      random_block(blk_b);
      build_ref(blk_a);
      @(negedge clock);
      blk_valid = 1'b1;
      blk_data  = blk_a;
      @(posedge clock);
      #1;
      blk_data = blk_b;
      run_stream(64, 1'b0);
      @(negedge clock);
      check("b2b_gap_w_valid", 32'(w_valid), 32'd0);
      check("b2b_gap_blk_ready", 32'(blk_ready), 32'd1);
      @(posedge clock);
      #1;
      blk_valid = 1'b0;
      build_ref(blk_b);
      run_stream(64, 1'b0);

      // Random blocks against the reference schedule
      for (int b = 0; b < 1000; b++) begin
         random_block(blk_a);
         build_ref(blk_a);
         send_block(blk_a);
         run_stream(64, 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
